// File: rtl/result_serializer_pkg.sv
// Shared types and defaults for the result serializer.
// Output FSM encoding and datapath sizing live here.
package result_serializer_pkg;

    localparam int DEF_DATAWIDTH = 32;
    localparam int DEF_DEPTH     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_Z = 2'd1,
        SEND_X = 2'd2
    } ser_state_e;

endpackage

// File: rtl/result_serializer_pair_fifo.sv
// Pair storage for the serializer: circular buffer of {z, x} words.
// Full and empty come from the occupancy counter, never the pointers.
module pair_fifo
    import result_serializer_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_DATAWIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; contents are don't-care.
    always_ff @(posedge Clk) begin
        if (!Rst && push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/result_serializer.sv
// Buffers (z, x) result pairs and streams them out as single words,
// z first then x, over valid/ready; drops pairs when full.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATAWIDTH-1:0]   z,
    input  logic signed [DATAWIDTH-1:0]   x,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATAWIDTH-1:0]   out_data,
    output logic                          out_last,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          overflow
);

    localparam int CW = $clog2(DEPTH + 1);

    ser_state_e state_q, state_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       overflow_q, overflow_d;

    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [2*DATAWIDTH-1:0] head;
    logic [CW-1:0]          fifo_count;

    pair_fifo #(
        .WIDTH (2 * DATAWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (push),
        .pop   (pop),
        .wdata ({z, x}),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state_q == SEND_X) && out_ready;

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q || (in_valid && full);
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SEND_Z;
                end
            end
            SEND_Z: begin
                if (out_ready) begin
                    state_d = SEND_X;
                end
            end
            SEND_X: begin
                // A same-cycle push keeps the stream going with no bubble.
                if (out_ready) begin
                    if (fifo_count > CW'(1) || push) begin
                        state_d = SEND_Z;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d != IDLE);
        out_last_d  = (state_d == SEND_X);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

    // Head only moves on pop, so this mux is stable under backpressure.
    always_comb begin
        out_data = '0;
        unique case (state_q)
            SEND_Z:  out_data = head[2*DATAWIDTH-1:DATAWIDTH];
            SEND_X:  out_data = head[DATAWIDTH-1:0];
            default: out_data = '0;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign count     = fifo_count;
    assign overflow  = overflow_q;

endmodule
